// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: multi-cycle IEEE-754 single-precision multiplier.
// Shift-add mantissa product (one step per cycle), normalise, RNE round, pack.
// Latency from accept edge to out_valid is a fixed 27 edges for every input:
// 24 shift-add edges, one MUL exit edge (counter reaches MUL_STEPS), NORM, ROUND.
module fp32_mul_seq #(
    parameter int unsigned MUL_STEPS = 24,
    parameter logic [31:0] QNAN      = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int unsigned MW = 24;   // mantissa width incl. hidden bit
    localparam int unsigned PW = 48;   // full product width
    localparam int unsigned CW = 5;    // step counter width
    localparam int unsigned EW = 10;   // signed exponent arithmetic width

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic             sign_q;
    logic [7:0]       ea_q, eb_q;
    logic [MW-1:0]    ma_q, mb_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             nan_q, inf_q, zero_q;
    logic [MW-2:0]    frac_q;
    logic             guard_q, sticky_q, exp_adj_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [31:0]      result_q;

    // Operand classification taken straight from the input bus at accept time
    logic [7:0]       a_exp_c, b_exp_c;
    logic             a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;

    always_comb begin
        a_exp_c  = op_a[30:23];
        b_exp_c  = op_b[30:23];
        a_nan_c  = (a_exp_c == 8'hFF) && (op_a[22:0] != 23'd0);
        b_nan_c  = (b_exp_c == 8'hFF) && (op_b[22:0] != 23'd0);
        a_inf_c  = (a_exp_c == 8'hFF) && (op_a[22:0] == 23'd0);
        b_inf_c  = (b_exp_c == 8'hFF) && (op_b[22:0] == 23'd0);
        a_zero_c = (a_exp_c == 8'd0);
        b_zero_c = (b_exp_c == 8'd0);
    end

    // One shift-add step: add multiplicand << cnt when multiplier bit[cnt] is set
    logic             mul_bit_d;
    logic [PW-1:0]    acc_d;

    always_comb begin
        mul_bit_d = 1'b0;
        if (cnt_q < CW'(MUL_STEPS)) begin
            mul_bit_d = mb_q[cnt_q];
        end
        acc_d = acc_q;
        if (mul_bit_d) begin
            acc_d = acc_q + (PW'(ma_q) << cnt_q);
        end
    end

    // Normalisation: select the 23-bit fraction, guard and sticky from the product
    logic [MW-2:0]    frac_d;
    logic             guard_d, sticky_d, exp_adj_d;

    always_comb begin
        if (acc_q[PW-1]) begin
            frac_d    = acc_q[46:24];
            guard_d   = acc_q[23];
            sticky_d  = |acc_q[22:0];
            exp_adj_d = 1'b1;
        end else begin
            frac_d    = acc_q[45:23];
            guard_d   = acc_q[22];
            sticky_d  = |acc_q[21:0];
            exp_adj_d = 1'b0;
        end
    end

    // Round-to-nearest-even, exponent computation and final packing
    logic                 round_up_d;
    logic [MW-1:0]        frac_sum_d;
    logic                 carry_d;
    logic signed [EW-1:0] exp_d;
    logic [31:0]          pack_d;

    always_comb begin
        round_up_d = guard_q & (sticky_q | frac_q[0]);
        frac_sum_d = {1'b0, frac_q} + MW'(round_up_d);
        carry_d    = frac_sum_d[MW-1];
        exp_d      = EW'(ea_q) + EW'(eb_q) + EW'(exp_adj_q) + EW'(carry_d) - EW'(127);

        if (nan_q || (inf_q && zero_q)) begin
            pack_d = QNAN;
        end else if (inf_q) begin
            pack_d = {sign_q, 8'hFF, 23'd0};
        end else if (zero_q) begin
            pack_d = {sign_q, 31'd0};
        end else if (exp_d >= 10'sd255) begin
            pack_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_d <= 10'sd0) begin
            pack_d = {sign_q, 31'd0};
        end else begin
            // A rounding carry leaves frac_sum_d[22:0] all zero, as required
            pack_d = {sign_q, exp_d[7:0], frac_sum_d[MW-2:0]};
        end
    end

    // Sequencer: state, datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            frac_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_adj_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_q     <= op_a[31] ^ op_b[31];
                        ea_q       <= a_exp_c;
                        eb_q       <= b_exp_c;
                        ma_q       <= {1'b1, op_a[22:0]};
                        mb_q       <= {1'b1, op_b[22:0]};
                        nan_q      <= a_nan_c | b_nan_c;
                        inf_q      <= a_inf_c | b_inf_c;
                        zero_q     <= a_zero_c | b_zero_c;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt_q == CW'(MUL_STEPS)) begin
                        state_q <= S_NORM;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_NORM: begin
                    frac_q    <= frac_d;
                    guard_q   <= guard_d;
                    sticky_q  <= sticky_d;
                    exp_adj_q <= exp_adj_d;
                    state_q   <= S_ROUND;
                end
                S_ROUND: begin
                    result_q    <= pack_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: reference model + expected-result queue.
module tb_fp32_mul_seq;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam int          LAT     = 27;
    localparam int          TIMEOUT = 60;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int tests;
    int fails;
    logic [31:0] sb_q[$];

    fp32_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FP32 multiply: flush-to-zero, RNE, canonical NaN
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return QNAN;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'd0 || eb == 8'd0) return QNAN;
            return {s, 8'hFF, 23'd0};
        end
        if (ea == 8'd0 || eb == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            e  = e + 1;
            m  = {1'b0, p[46:24]};
            g  = p[23];
            st = |p[22:0];
        end else begin
            m  = {1'b0, p[45:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m[22:0]};
    endfunction

    // One transaction with out_ready held high: accept, latency, result, release
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int          cyc;
        logic [31:0] exp_v;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(ref_mul(a, b));
        cyc = 0;
        while (!out_valid && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc !== LAT) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles required %0d", tag, cyc, LAT);
        end
        if (out_valid === 1'b1) begin
            exp_v = sb_q.pop_front();
            tests++;
            if (result !== exp_v) begin
                fails++;
                $display("FAIL %s result: a=%h b=%h got %h required %h", tag, a, b, result, exp_v);
            end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                         tag, out_valid, in_ready, busy);
            end
        end else begin
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        #2 rst_n = 1'b0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h busy=%b required 1 0 0 0",
                     in_ready, out_valid, result, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        logic [31:0] vr[8];
        va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vr[0] = 32'h40400000;
        va[1] = 32'h3F800001; vb[1] = 32'h3FC00000; vr[1] = 32'h3FC00002;
        va[2] = 32'h7F000000; vb[2] = 32'h40000000; vr[2] = 32'h7F800000;
        va[3] = 32'h00800000; vb[3] = 32'h00800000; vr[3] = 32'h00000000;
        va[4] = 32'hBF800000; vb[4] = 32'h40000000; vr[4] = 32'hC0000000;
        va[5] = 32'h7F800000; vb[5] = 32'h00000000; vr[5] = 32'h7FC00000;
        va[6] = 32'h7FC00001; vb[6] = 32'h3F800000; vr[6] = 32'h7FC00000;
        va[7] = 32'hFF800000; vb[7] = 32'h3F800000; vr[7] = 32'hFF800000;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (ref_mul(va[i], vb[i]) !== vr[i]) begin
                fails++;
                $display("FAIL model_vec%0d: model %h required %h", i, ref_mul(va[i], vb[i]), vr[i]);
            end
            run_op(va[i], vb[i], $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) begin
                a = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 165)), 23'($urandom)};
                b = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 165)), 23'($urandom)};
            end else begin
                a = $urandom;
                b = $urandom;
            end
            run_op(a, b, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_backpressure();
        int          cyc;
        logic [31:0] exp_v;
        logic [31:0] held;
        out_ready = 1'b0;
        op_a      = 32'h3FC00000;
        op_b      = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(ref_mul(op_a, op_b));
        cyc = 0;
        while (!out_valid && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc !== LAT) begin
            fails++;
            $display("FAIL bp_latency: got %0d cycles required %0d", cyc, LAT);
        end
        exp_v = sb_q.pop_front();
        tests++;
        if (result !== exp_v) begin
            fails++;
            $display("FAIL bp_result: got %h required %h", result, exp_v);
        end
        held     = exp_v;
        op_a     = 32'h40400000;
        op_b     = 32'h40400000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: result=%h out_valid=%b in_ready=%b required %h 1 0",
                         i, result, out_valid, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_ignored_op: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        out_ready = 1'b1;
        op_a      = 32'h3FC00000;
        op_b      = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b result=%h busy=%b required 1 0 0 0",
                     in_ready, out_valid, result, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_output: activity seen=%b required 0", seen);
        end
        run_op(32'hBF800000, 32'h40000000, "after_reset");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier sequencer.
- Accepts one operand pair through a valid/ready handshake and computes the 24x24 mantissa product iteratively, one shift-add step per cycle.
- Normalises and rounds the 48-bit product (round-to-nearest-even), then packs and returns the result through a second valid/ready handshake.
- Sits between the FP issue logic and the writeback stage; it is the sequencing controller for the shared mantissa-product and rounding datapath.

Parameters:
- MUL_STEPS, 24, number of shift-add iterations; equals the mantissa width including the hidden bit. Fixed at 24 for FP32.
- QNAN, 32'h7FC00000, canonical NaN value produced for invalid operations.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- op_a  input  32  FP32 operand A
- op_b  input  32  FP32 operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  FP32 product
- busy  output  1  operation in flight (any state except IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; busy=0. Accumulator, step counter and operand registers are cleared.
- Reset mid-operation aborts the operation. No result is ever produced for that operation.
- States: IDLE -> MUL -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sign, exponents, and mantissas (hidden bit prepended), clear the 48-bit accumulator and counter, go to MUL.
  - Also latch the special-case flags listed below.
- MUL:
  - One step per cycle: if multiplier bit[cnt]=1, add the multiplicand shifted left by cnt into the accumulator. Then cnt++.
  - After MUL_STEPS cycles go to NORM.
- NORM:
  - If p[47]=1: frac=p[46:24], guard=p[23], sticky=|p[22:0], exp_adj=1.
  - Else: frac=p[45:23], guard=p[22], sticky=|p[21:0], exp_adj=0.
- ROUND:
  - Round up iff guard && (sticky || frac[0]).
  - A carry out of frac (all ones +1) sets frac=0 and increments the exponent.
  - Exponent arithmetic is 10-bit signed: e = ea + eb - 127 + exp_adj + carry.
- DONE:
  - out_valid=1 and result is held stable until out_ready is sampled high.
  - The cycle after the out_valid&&out_ready transfer: state=IDLE, out_valid=0.
  - in_ready=0 in every state except IDLE. No operand is accepted while a result is pending.
- Latency: the accept edge is cycle 0; out_valid rises after the edge of cycle 27 (24 MUL + NORM + ROUND + DONE entry).
  - Latency is fixed for all inputs, including the special cases.
- Packing:
  - Sign = sa^sb.
  - e>=255 -> {sign, 8'hFF, 23'b0} (infinity).
  - e<=0 -> {sign, 31'b0}. Denormal outputs are flushed to zero.
- Special cases (decided from the latched operands; they override the datapath result):
  - Either operand exp=0 is treated as zero; denormal inputs are flushed.
  - Either operand NaN -> QNAN.
  - Inf*zero -> QNAN.
  - Inf*finite nonzero or inf*inf -> signed infinity.
  - Zero*finite -> signed zero.
- Simultaneous events: out_ready may be held high before out_valid rises; the result is then consumed on the first DONE cycle.
  - in_valid asserted while busy is ignored. The upstream stage holds its operands until it sees in_ready.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> result=0x40400000; out_valid 27 cycles after accept.
- 0x3F800001 * 0x3FC00000 (tie, odd LSB) -> 0x3FC00002, confirming round-to-nearest-even round-up.
- 0x7F000000 * 0x40000000 -> 0x7F800000 (overflow to +inf). 0x00800000 * 0x00800000 -> 0x00000000 (underflow flush).
- 0xBF800000 * 0x40000000 -> 0xC0000000. 0x7F800000 * 0x00000000 -> 0x7FC00000. 0x7FC00001 * 0x3F800000 -> 0x7FC00000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: result stays stable, in_ready=0, and a new in_valid is ignored.
  - Then raise out_ready: result transfers, and in_ready=1 next cycle.
- Reset: pulse rst_n low at cycle 12 of MUL -> outputs return to reset values immediately; no out_valid follows. A subsequent operation completes with correct 27-cycle latency.
